fetch_ctrl: RTL and testbench

Pipeline sequencing controller for the fetch stage and IF/ID, ID/EX and EX/MEM registers. Each cycle it decides the fetch-side actions:
- whether the PC advances, holds or redirects to `ex_mem_npc`;
- whether IF/ID loads, holds or flushes;
- where bubbles go for branch flush, load-use hazards and instruction-memory wait states.

It also keeps saturating stall and flush counters for performance debug. It sits beside `fetch` and drives that block's PC/IF-ID enables from the hazard and memory-ready inputs.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/load_use_detect.sv | 18 +
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage sequencing controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int          FETCH_REG_ADDR_W = 5;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds either source of the instruction in ID.
module load_use_detect
  import fetch_pkg::*;
#(
  parameter int REG_ADDR_W = FETCH_REG_ADDR_W
) (
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  output logic                  hazard
);

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign hazard = id_ex_mem_read && (id_ex_rt != '0) &&
                  ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-side sequencing FSM: PC/IF-ID enables, bubble placement and perf counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int RESET_CYCLES = 2,
  parameter int REG_ADDR_W   = FETCH_REG_ADDR_W,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_mem_pc_src,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  imem_ready,
  output logic                  imem_req,
  output logic                  pc_we,
  output logic                  pc_sel,
  output logic                  if_id_we,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [3:0] INIT_LOAD = 4'(RESET_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fetch_state_t     state_q, state_d;
  logic [3:0]       init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hazard;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt),
    .hazard         (hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= INIT_LOAD;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    imem_req     = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    case (state_q)
      INIT: begin
        // Pipeline is held full of bubbles until the start-up countdown expires.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        if (init_cnt_q <= 4'd1) begin
          init_cnt_d = 4'd0;
          state_d    = RUN;
        end else begin
          init_cnt_d = init_cnt_q - 4'd1;
        end
      end
      default: begin
        imem_req = 1'b1;
        // Priority: redirect, then memory wait, then load-use, then normal advance.
        if (ex_mem_pc_src) begin
          pc_we        = 1'b1;
          pc_sel       = 1'b1;
          if_id_we     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_cnt_d  = sat_inc(flush_cnt_q);
          state_d      = RUN;
        end else if (!imem_ready) begin
          if_id_we    = 1'b1;
          if_id_flush = 1'b1;
          stall_cnt_d = sat_inc(stall_cnt_q);
          state_d     = MEMWAIT;
        end else if (hazard) begin
          id_ex_flush = 1'b1;
          stall_cnt_d = sat_inc(stall_cnt_q);
          state_d     = RUN;
        end else begin
          pc_we    = 1'b1;
          if_id_we = 1'b1;
          state_d  = RUN;
        end
      end
    endcase
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a rule-level reference model (16- and 4-bit counter builds).
module tb_fetch_ctrl;

  localparam int RST_CYC = 2;
  localparam int RAW     = 5;

  // Output vector order: imem_req, pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush
  localparam logic [6:0] V_INIT     = 7'b0000111;
  localparam logic [6:0] V_REDIRECT = 7'b1111111;
  localparam logic [6:0] V_MEMWAIT  = 7'b1001100;
  localparam logic [6:0] V_LOADUSE  = 7'b1000010;
  localparam logic [6:0] V_NORMAL   = 7'b1101000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pc_src = 1'b0;
  logic           mem_read = 1'b0;
  logic [RAW-1:0] ex_rt = '0;
  logic [RAW-1:0] rs = '0;
  logic [RAW-1:0] rt = '0;
  logic           ready = 1'b1;

  logic imem_req, pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush;
  logic imem_req4, pc_we4, pc_sel4, if_id_we4, if_id_flush4, id_ex_flush4, ex_mem_flush4;
  logic [15:0] stall16, flush16;
  logic [3:0]  stall4, flush4;
  logic [6:0]  outs, outs4;

  assign outs  = {imem_req, pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush};
  assign outs4 = {imem_req4, pc_we4, pc_sel4, if_id_we4, if_id_flush4, id_ex_flush4, ex_mem_flush4};

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_CYCLES(RST_CYC), .REG_ADDR_W(RAW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_mem_pc_src(pc_src), .id_ex_mem_read(mem_read),
    .id_ex_rt(ex_rt), .if_id_rs(rs), .if_id_rt(rt), .imem_ready(ready),
    .imem_req(imem_req), .pc_we(pc_we), .pc_sel(pc_sel), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .stall_cnt(stall16), .flush_cnt(flush16)
  );

  fetch_ctrl #(.RESET_CYCLES(RST_CYC), .REG_ADDR_W(RAW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ex_mem_pc_src(pc_src), .id_ex_mem_read(mem_read),
    .id_ex_rt(ex_rt), .if_id_rs(rs), .if_id_rt(rt), .imem_ready(ready),
    .imem_req(imem_req4), .pc_we(pc_we4), .pc_sel(pc_sel4), .if_id_we(if_id_we4),
    .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4), .ex_mem_flush(ex_mem_flush4),
    .stall_cnt(stall4), .flush_cnt(flush4)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: startup countdown plus unbounded event counts, saturated on compare.
  bit running;
  int countdown;
  int m_stall, m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic bit m_hazard();
    return mem_read && (ex_rt != 0) && ((ex_rt == rs) || (ex_rt == rt));
  endfunction

  function automatic logic [6:0] m_outs();
    if (!running)   return V_INIT;
    if (pc_src)     return V_REDIRECT;
    if (!ready)     return V_MEMWAIT;
    if (m_hazard()) return V_LOADUSE;
    return V_NORMAL;
  endfunction

  task automatic model_reset();
    running   = 1'b0;
    countdown = RST_CYC;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_outs"},    32'(outs),    32'(m_outs()));
    check({tag, "_outs4"},   32'(outs4),   32'(m_outs()));
    check({tag, "_stall16"}, 32'(stall16), 32'(sat(m_stall, 65535)));
    check({tag, "_flush16"}, 32'(flush16), 32'(sat(m_flush, 65535)));
    check({tag, "_stall4"},  32'(stall4),  32'(sat(m_stall, 15)));
    check({tag, "_flush4"},  32'(flush4),  32'(sat(m_flush, 15)));
  endtask

  // Inputs are already driven; compare mid-cycle, then advance the model on the edge.
  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    if (!running) begin
      countdown--;
      if (countdown == 0) running = 1'b1;
    end else if (pc_src) begin
      m_flush++;
    end else if (!ready || m_hazard()) begin
      m_stall++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    pc_src = 1'b0; mem_read = 1'b0; ex_rt = '0; rs = '0; rt = '0; ready = 1'b1;
  endtask

  int base;

  initial begin
    model_reset();
    #10;
    check_all("in_reset");
    @(posedge clk);
    #2 rst = 1'b0;

    // Startup: a redirect request during INIT must be ignored.
    pc_src = 1'b1;
    step("init0");
    pc_src = 1'b0;
    step("init1");
    @(negedge clk);
    check("first_pc_we", 32'(pc_we), 32'd1);
    check("first_stall", 32'(stall16), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) step("normal");

    pc_src = 1'b1;
    step("redirect");
    pc_src = 1'b0;
    check("redirect_flush_cnt", 32'(flush16), 32'd1);
    step("after_redirect");

    mem_read = 1'b1; ex_rt = 5'd5; rs = 5'd5; rt = 5'd9;
    step("load_use");
    check("load_use_stall", 32'(stall16), 32'd1);
    idle_inputs();
    step("after_load_use");
    mem_read = 1'b1; ex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
    step("load_r0");
    check("load_r0_stall", 32'(stall16), 32'd1);
    idle_inputs();

    base = m_stall;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) step("memwait");
    check("memwait_stall", 32'(stall16), 32'(base + 3));
    ready = 1'b1;
    step("resume");

    pc_src = 1'b1; ready = 1'b0; mem_read = 1'b1; ex_rt = 5'd3; rs = 5'd3;
    base = m_stall;
    step("simul");
    check("simul_stall", 32'(stall16), 32'(base));
    idle_inputs();
    step("after_simul");

    for (int i = 0; i < 400; i++) begin
      pc_src   = ($urandom_range(0, 9) == 0);
      ready    = ($urandom_range(0, 3) != 0);
      mem_read = $urandom_range(0, 1) == 1;
      ex_rt    = 5'($urandom_range(0, 3));
      rs       = 5'($urandom_range(0, 3));
      rt       = 5'($urandom_range(0, 3));
      step("rand");
    end

    // Asynchronous reset in the middle of a memory wait.
    idle_inputs();
    ready = 1'b0;
    step("pre_rst_wait0");
    step("pre_rst_wait1");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    ready = 1'b1;
    step("reinit0");
    step("reinit1");

    ready = 1'b0;
    for (int i = 0; i < 20; i++) step("sat");
    check("sat_stall4", 32'(stall4), 32'd15);
    check("sat_stall16", 32'(stall16), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
